// File: rtl/triad_decoder_if.sv
// Triad decoder bus: serial triad inputs, counter clear, and the decoded hit outputs.
interface triad_decoder_if #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned CNT_W = 16
);
    logic [NCH-1:0]   triad_in;
    logic             cnt_clr;
    logic [4*NCH-1:0] hs_out;
    logic             hit_valid;
    logic [CNT_W-1:0] triad_cnt;
    logic [NCH-1:0]   busy;

    modport master (
        output triad_in, cnt_clr,
        input  hs_out, hit_valid, triad_cnt, busy
    );

    modport slave (
        input  triad_in, cnt_clr,
        output hs_out, hit_valid, triad_cnt, busy
    );
endinterface

// File: rtl/triad_decoder.sv
// Deserializes per-channel 3-bit triads (start, strip, half-strip) into stretched
// one-hot half-strip hits, with a saturating count of completed triads.
module triad_decoder #(
    parameter int unsigned NCH     = 8,
    parameter int unsigned PERSIST = 6,
    parameter int unsigned CNT_W   = 16
) (
    input logic             clock,
    input logic             reset_n,
    triad_decoder_if.slave  bus
);
    localparam int unsigned PC_W  = $clog2(PERSIST + 1);
    localparam int unsigned SUM_W = CNT_W + $clog2(NCH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StS1, StS2} state_e;

    state_e            state_q [NCH];
    state_e            state_d [NCH];
    logic [NCH-1:0]    sb_q, sb_d, done;
    logic [PC_W-1:0]   pc_q [NCH][4];
    logic [PC_W-1:0]   pc_d [NCH][4];
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hit_valid_q;
    logic [4*NCH-1:0]  hs;
    logic [NCH-1:0]    busy;

    always_comb begin
        sum = SUM_W'(cnt_q);
        for (int ch = 0; ch < NCH; ch++) begin
            state_d[ch] = state_q[ch];
            sb_d[ch]    = sb_q[ch];
            done[ch]    = 1'b0;
            unique case (state_q[ch])
                StIdle: if (bus.triad_in[ch]) state_d[ch] = StS1;
                StS1: begin
                    sb_d[ch]    = bus.triad_in[ch];
                    state_d[ch] = StS2;
                end
                StS2: begin
                    done[ch]    = 1'b1;
                    state_d[ch] = StIdle;
                end
                default: state_d[ch] = StIdle;
            endcase
            sum = sum + SUM_W'(done[ch]);
        end
        if (bus.cnt_clr)       cnt_d = '0;
        else if (sum > CNT_MAX) cnt_d = '1;
        else                   cnt_d = sum[CNT_W-1:0];
    end

    // hb is taken straight from the input in S2, so the decode lands on the same edge.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            busy[ch] = (state_q[ch] != StIdle);
            for (int i = 0; i < 4; i++) begin
                if (done[ch] && ({sb_q[ch], bus.triad_in[ch]} == 2'(i))) begin
                    pc_d[ch][i] = PC_W'(PERSIST);
                end else if (pc_q[ch][i] != '0) begin
                    pc_d[ch][i] = pc_q[ch][i] - PC_W'(1);
                end else begin
                    pc_d[ch][i] = pc_q[ch][i];
                end
                hs[4*ch+i] = (pc_q[ch][i] != '0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= StIdle;
                for (int i = 0; i < 4; i++) pc_q[ch][i] <= '0;
            end
            sb_q        <= '0;
            cnt_q       <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= state_d[ch];
                for (int i = 0; i < 4; i++) pc_q[ch][i] <= pc_d[ch][i];
            end
            sb_q        <= sb_d;
            cnt_q       <= cnt_d;
            hit_valid_q <= |done;
        end
    end

    assign bus.hs_out    = hs;
    assign bus.hit_valid = hit_valid_q;
    assign bus.triad_cnt = cnt_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_triad_decoder.sv
// Bench for triad_decoder: directed scenarios plus randomized traffic against a
// timestamp-based reference model; a CNT_W=4 instance shares stimulus for saturation.
module tb_triad_decoder;
    localparam int NCH = 8;
    localparam int PERSIST = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [NCH-1:0] triad_in = '0;
    logic cnt_clr = 1'b0;

    int total = 0;
    int bad = 0;

    triad_decoder_if #(.NCH(NCH), .CNT_W(16)) bus16 ();
    triad_decoder_if #(.NCH(NCH), .CNT_W(4))  bus4 ();

    assign bus16.triad_in = triad_in;
    assign bus16.cnt_clr  = cnt_clr;
    assign bus4.triad_in  = triad_in;
    assign bus4.cnt_clr   = cnt_clr;

    triad_decoder #(.NCH(NCH), .PERSIST(PERSIST), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    triad_decoder #(.NCH(NCH), .PERSIST(PERSIST), .CNT_W(4)) dut_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    always #5 clock = ~clock;

    // Reference model: per-channel bit position, hit expiry timestamps, counts.
    int cyc = 0;
    int m_pos [NCH];
    bit m_sb [NCH];
    int m_exp [NCH][4];
    int m_cnt = 0;
    int m_cnt4 = 0;
    bit m_hv = 0;

    function automatic logic [4*NCH-1:0] exp_hs();
        logic [4*NCH-1:0] v = '0;
        for (int ch = 0; ch < NCH; ch++)
            for (int i = 0; i < 4; i++) v[4*ch+i] = (cyc < m_exp[ch][i]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] v = '0;
        for (int ch = 0; ch < NCH; ch++) v[ch] = (m_pos[ch] != 0);
        return v;
    endfunction

    task automatic step();
        int ndone;
        @(posedge clock);
        cyc++;
        ndone = 0;
        if (!reset_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_pos[ch] = 0;
                for (int i = 0; i < 4; i++) m_exp[ch][i] = 0;
            end
            m_cnt = 0;
            m_cnt4 = 0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_pos[ch] == 0) begin
                    if (triad_in[ch]) m_pos[ch] = 1;
                end else if (m_pos[ch] == 1) begin
                    m_sb[ch] = triad_in[ch];
                    m_pos[ch] = 2;
                end else begin
                    m_exp[ch][2*int'(m_sb[ch]) + int'(triad_in[ch])] = cyc + PERSIST;
                    ndone++;
                    m_pos[ch] = 0;
                end
            end
            if (cnt_clr) begin
                m_cnt = 0;
                m_cnt4 = 0;
            end else begin
                m_cnt = (m_cnt + ndone > 65535) ? 65535 : m_cnt + ndone;
                m_cnt4 = (m_cnt4 + ndone > 15) ? 15 : m_cnt4 + ndone;
            end
        end
        m_hv = (ndone > 0);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        triad_in = '0;
        cnt_clr = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            triad_in = NCH'($urandom);
            step();
        end
        total++; if (bus16.hs_out !== '0) begin bad++; $display("FAIL reset hs_out got %h want 0", bus16.hs_out); end
        total++; if (bus16.hit_valid !== 1'b0) begin bad++; $display("FAIL reset hit_valid got %b want 0", bus16.hit_valid); end
        total++; if (bus16.triad_cnt !== '0) begin bad++; $display("FAIL reset triad_cnt got %0d want 0", bus16.triad_cnt); end
        total++; if (bus16.busy !== '0) begin bad++; $display("FAIL reset busy got %b want 0", bus16.busy); end
        reset_n = 1'b1;
        triad_in = '0;
    endtask

    task automatic test_single();
        do_reset();
        triad_in = 8'h01; step();
        total++; if (bus16.busy !== 8'h01) begin bad++; $display("FAIL single busy got %b want 00000001", bus16.busy); end
        triad_in = 8'h01; step();
        triad_in = 8'h00; step();
        total++; if (bus16.triad_cnt !== 16'd1) begin bad++; $display("FAIL single triad_cnt got %0d want 1", bus16.triad_cnt); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus16.hs_out !== ((i < PERSIST) ? 32'h4 : 32'h0)) begin
                bad++; $display("FAIL single hs_out step %0d got %h", i, bus16.hs_out);
            end
            total++;
            if (bus16.hit_valid !== (i == 0)) begin
                bad++; $display("FAIL single hit_valid step %0d got %b want %b", i, bus16.hit_valid, i == 0);
            end
            step();
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            triad_in = (i < 6) ? 8'h08 : 8'h00;
            step();
            total++;
            if (bus16.hs_out !== ((i >= 2 && i <= 10) ? 32'h8000 : 32'h0)) begin
                bad++; $display("FAIL retrigger hs_out step %0d got %h", i, bus16.hs_out);
            end
        end
        total++; if (bus16.triad_cnt !== 16'd2) begin bad++; $display("FAIL retrigger triad_cnt got %0d want 2", bus16.triad_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] bits = 6'b101001;  // sent LSB first: 1,0,0 then 1,0,1
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            triad_in = (i < 6) ? {6'b0, bits[i], 1'b0} : 8'h00;
            step();
            want = {2'b00, (i >= 5 && i <= 10), (i >= 2 && i <= 7)};
            total++;
            if (bus16.hs_out[7:4] !== want) begin
                bad++; $display("FAIL back_to_back hs_out[7:4] step %0d got %b want %b", i, bus16.hs_out[7:4], want);
            end
        end
        total++; if (bus16.triad_cnt !== 16'd2) begin bad++; $display("FAIL back_to_back triad_cnt got %0d want 2", bus16.triad_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        triad_in = 8'h04; step();
        total++; if (bus16.busy !== 8'h04) begin bad++; $display("FAIL reset_mid busy pre got %b want 00000100", bus16.busy); end
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        total++; if (bus16.busy !== 8'h00) begin bad++; $display("FAIL reset_mid busy post got %b want 0", bus16.busy); end
        triad_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus16.hs_out !== '0) begin bad++; $display("FAIL reset_mid hs_out step %0d got %h want 0", i, bus16.hs_out); end
        end
        total++; if (bus16.triad_cnt !== 16'd0) begin bad++; $display("FAIL reset_mid triad_cnt got %0d want 0", bus16.triad_cnt); end
    endtask

    task automatic test_saturate();
        logic [2:0] pat = 3'b101;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            triad_in = {NCH{pat[i % 3]}};
            step();
            if (i == 2) begin
                total++; if (bus4.triad_cnt !== 4'd8) begin bad++; $display("FAIL saturate first cnt got %0d want 8", bus4.triad_cnt); end
            end
        end
        total++; if (bus4.triad_cnt !== 4'd15) begin bad++; $display("FAIL saturate cnt4 got %0d want 15", bus4.triad_cnt); end
        total++; if (bus16.triad_cnt !== 16'd16) begin bad++; $display("FAIL saturate cnt16 got %0d want 16", bus16.triad_cnt); end
        triad_in = 8'hff; step();
        triad_in = 8'h00; step();
        triad_in = 8'hff; cnt_clr = 1'b1; step();
        total++; if (bus4.triad_cnt !== 4'd0) begin bad++; $display("FAIL saturate clr cnt4 got %0d want 0", bus4.triad_cnt); end
        total++; if (bus16.triad_cnt !== 16'd0) begin bad++; $display("FAIL saturate clr cnt16 got %0d want 0", bus16.triad_cnt); end
        total++; if (bus16.hit_valid !== 1'b1) begin bad++; $display("FAIL saturate clr hit_valid got %b want 1", bus16.hit_valid); end
        triad_in = 8'h00; cnt_clr = 1'b0; step();
        total++; if (bus4.triad_cnt !== 4'd0) begin bad++; $display("FAIL saturate after clr cnt4 got %0d want 0", bus4.triad_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 63) != 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            triad_in = NCH'($urandom);
            if (n < 200) triad_in[7] = 1'b1;
            step();
            total++; if (bus16.hs_out !== exp_hs()) begin bad++; $display("FAIL random hs_out cyc %0d got %h want %h", cyc, bus16.hs_out, exp_hs()); end
            total++; if (bus16.hit_valid !== m_hv) begin bad++; $display("FAIL random hit_valid cyc %0d got %b want %b", cyc, bus16.hit_valid, m_hv); end
            total++; if (bus16.busy !== exp_busy()) begin bad++; $display("FAIL random busy cyc %0d got %b want %b", cyc, bus16.busy, exp_busy()); end
            total++; if (int'(bus16.triad_cnt) !== m_cnt) begin bad++; $display("FAIL random cnt16 cyc %0d got %0d want %0d", cyc, bus16.triad_cnt, m_cnt); end
            total++; if (int'(bus4.triad_cnt) !== m_cnt4) begin bad++; $display("FAIL random cnt4 cyc %0d got %0d want %0d", cyc, bus4.triad_cnt, m_cnt4); end
        end
        reset_n = 1'b1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        for (int ch = 0; ch < NCH; ch++) begin
            m_pos[ch] = 0;
            m_sb[ch] = 1'b0;
            for (int i = 0; i < 4; i++) m_exp[ch][i] = 0;
        end
        test_reset();
        test_single();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
